alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 6 +
 rtl/addsub_unit.sv | 29 ++
 rtl/alu_issue_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default datapath width and op encodings.
package alu_pkg;
  localparam int   ALU_WIDTH = 9;
  localparam logic OP_ADD    = 1'b1;
  localparam logic OP_SUB    = 1'b0;
endpackage

// File: rtl/addsub_unit.sv
// Purely combinational add/subtract with carry/borrow and signed-overflow flags.
module addsub_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);
  logic [WIDTH:0] sum;
  logic           sign_a, sign_b, sign_r;

  always_comb begin
    // The extra top bit is the carry on add and the borrow (a < b) on subtract.
    if (op == OP_ADD) sum = {1'b0, a} + {1'b0, b};
    else              sum = {1'b0, a} - {1'b0, b};
    result = sum[WIDTH-1:0];
    carry  = sum[WIDTH];
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1];
    sign_r = sum[WIDTH-1];
    if (op == OP_ADD) ovf = (sign_a == sign_b) && (sign_r != sign_a);
    else              ovf = (sign_a != sign_b) && (sign_r != sign_a);
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ready/valid ALU issue stage: operand register (p1) then result/flag register (p2).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [15:0]      op_count
);
  logic             vld_p1_q, vld_p1_d;
  logic             op_p1_q, op_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic [WIDTH-1:0] b_p1_q, b_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] res_p2_q, res_p2_d;
  logic             carry_p2_q, carry_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic             ovf_p2_q, ovf_p2_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;
  logic             s2_load, s1_adv, in_fire, out_fire;

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a      (a_p1_q),
    .b      (b_p1_q),
    .op     (op_p1_q),
    .result (alu_res),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  always_comb begin
    s2_load  = !vld_p2_q || out_ready;
    s1_adv   = vld_p1_q && s2_load;
    in_ready = !rst && !flush && (!vld_p1_q || s1_adv);
    in_fire  = in_valid && in_ready;
    out_fire = vld_p2_q && out_ready;

    // p0 -> p1: capture operands on an input transfer
    vld_p1_d = vld_p1_q && !s1_adv;
    if (in_fire) vld_p1_d = 1'b1;
    if (flush)   vld_p1_d = 1'b0;
    op_p1_d = in_fire ? in_op : op_p1_q;
    a_p1_d  = in_fire ? in_a  : a_p1_q;
    b_p1_d  = in_fire ? in_b  : b_p1_q;

    // p1 -> p2: result and flags only move when the output slot frees up
    vld_p2_d = s2_load ? vld_p1_q : vld_p2_q;
    if (flush) vld_p2_d = 1'b0;
    res_p2_d   = s1_adv ? alu_res            : res_p2_q;
    carry_p2_d = s1_adv ? alu_carry          : carry_p2_q;
    zero_p2_d  = s1_adv ? (alu_res == '0)    : zero_p2_q;
    ovf_p2_d   = s1_adv ? alu_ovf            : ovf_p2_q;

    cnt_d = out_fire ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      res_p2_q   <= '0;
      carry_p2_q <= 1'b0;
      zero_p2_q  <= 1'b0;
      ovf_p2_q   <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      res_p2_q   <= res_p2_d;
      carry_p2_q <= carry_p2_d;
      zero_p2_q  <= zero_p2_d;
      ovf_p2_q   <= ovf_p2_d;
      cnt_q      <= cnt_d;
    end
  end

  // Operand register carries no reset: its contents are qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    op_p1_q <= op_p1_d;
    a_p1_q  <= a_p1_d;
    b_p1_q  <= b_p1_d;
  end

  assign out_valid  = vld_p2_q;
  assign out_result = res_p2_q;
  assign out_carry  = carry_p2_q;
  assign out_zero   = zero_p2_q;
  assign out_ovf    = ovf_p2_q;
  assign op_count   = cnt_q;
endmodule
